// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with a 1-entry skid buffer and a registered in_ready.
// Optional `PIPE_STAGE_PERF_EN adds saturating bubble/flush event counters.
module pipe_stage_buf #(
    parameter int unsigned CTRL_W         = 64,
    parameter int unsigned KEEP_W         = 33,
    parameter logic [31:0] FLUSH_KEEP_RST = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [KEEP_W-1:0] in_keep,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [KEEP_W-1:0] out_keep,
    input  logic              flush,
    input  logic [KEEP_W-1:0] flush_keep,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [KEEP_W-1:0] KEEP_RST = KEEP_W'(FLUSH_KEEP_RST);

    // Encoding is {out_valid, skid_valid}; 2'b01 cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [KEEP_W-1:0] out_keep_q, out_keep_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [KEEP_W-1:0] skid_keep_q, skid_keep_d;
    logic              skid_valid;
    logic              in_xfer;
    logic              out_xfer;
    logic              bubble;

    assign out_valid  = state_q[1];
    assign skid_valid = state_q[0];
    assign in_ready   = ~skid_valid;
    assign occupancy  = {1'b0, out_valid} + {1'b0, skid_valid};
    assign out_ctrl   = out_ctrl_q;
    assign out_keep   = out_keep_q;
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        out_ctrl_d  = out_ctrl_q;
        out_keep_d  = out_keep_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_keep_d = skid_keep_q;
        bubble      = 1'b0;
        if (flush) begin
            state_d     = EMPTY;
            out_ctrl_d  = '0;
            out_keep_d  = flush_keep;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d    = ONE;
                        out_ctrl_d = in_ctrl;
                        out_keep_d = in_keep;
                    end else begin
                        bubble = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_ctrl_d = in_ctrl;
                        out_keep_d = in_keep;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                        bubble  = 1'b1;
                    end else if (in_xfer) begin
                        state_d     = FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_keep_d = in_keep;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d     = ONE;
                        out_ctrl_d  = skid_ctrl_q;
                        out_keep_d  = skid_keep_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        // KEEP follows upstream on a bubble so PC/BD stay valid for interrupts.
        if (bubble) begin
            out_ctrl_d = '0;
            out_keep_d = in_keep;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            out_ctrl_q  <= '0;
            out_keep_q  <= KEEP_RST;
            skid_ctrl_q <= '0;
            skid_keep_q <= '0;
        end else begin
            state_q     <= state_d;
            out_ctrl_q  <= out_ctrl_d;
            out_keep_q  <= out_keep_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_keep_q <= skid_keep_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, async reset check,
// and random traffic against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam int CW = 64;
    localparam int KW = 33;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [KW-1:0] in_keep;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [KW-1:0] out_keep;
    logic          flush;
    logic [KW-1:0] flush_keep;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   bubble_cnt;
    logic [31:0]   flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_keep    (in_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_keep   (out_keep),
        .flush      (flush),
        .flush_keep (flush_keep),
        .occupancy  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [KW-1:0] ik;
        logic          ordy;
        logic          fl;
        logic [KW-1:0] fk;
        logic          ev;
        logic [CW-1:0] ec;
        logic [KW-1:0] ek;
        logic          erdy;
        logic [1:0]    eocc;
    } vec_t;

    typedef struct {
        logic [CW-1:0] c;
        logic [KW-1:0] k;
    } ent_t;

    vec_t          vecs[$];
    ent_t          mq[$];
    logic [KW-1:0] m_keep;
    logic [31:0]   m_bub;
    logic [31:0]   m_fl;

    function automatic logic [KW-1:0] pk(input logic [31:0] pc, input logic bd);
        return {pc, bd};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic iv, input logic [CW-1:0] ic, input logic [KW-1:0] ik,
                        input logic ordy, input logic fl, input logic [KW-1:0] fk,
                        input logic ev, input logic [CW-1:0] ec, input logic [KW-1:0] ek,
                        input logic erdy, input logic [1:0] eocc);
        vec_t v;
        v = '{iv, ic, ik, ordy, fl, fk, ev, ec, ek, erdy, eocc};
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        mq.delete();
        m_keep = 33'h0_0000_3000;
        m_bub  = '0;
        m_fl   = '0;
    endtask

    // Reference: a queue of at most two entries; KEEP follows upstream whenever empty.
    task automatic model_step();
        logic rdy;
        ent_t e;
        rdy = (mq.size() < 2);
        if (flush) begin
            mq.delete();
            m_keep = flush_keep;
            if (m_fl != 32'hFFFF_FFFF) m_fl = m_fl + 1;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) begin
                e.c = in_ctrl;
                e.k = in_keep;
                mq.push_back(e);
            end
            if (mq.size() == 0) begin
                m_keep = in_keep;
                if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
            end
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_bub));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_fl));
`else
        if (tag == "") $display("tb: empty tag");
`endif
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({tag, ".out_ctrl"}, out_ctrl, (mq.size() != 0) ? mq[0].c : '0);
        chk({tag, ".out_keep"}, 64'(out_keep), 64'((mq.size() != 0) ? mq[0].k : m_keep));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < 2));
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
        check_perf(tag);
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [KW-1:0] ik,
                         input logic ordy, input logic fl, input logic [KW-1:0] fk);
        in_valid   = iv;
        in_ctrl    = ic;
        in_keep    = ik;
        out_ready  = ordy;
        flush      = fl;
        flush_keep = fk;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        check_model("rst0");
        reset = 1'b1;

        // Async reset while holding an entry.
        drive(1'b1, 64'hA5, pk(32'h100, 1'b0), 1'b0, 1'b0, '0);
        model_step();
        @(posedge clk);
        #1;
        check_model("pre_rst");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.out_ctrl", out_ctrl, 64'd0);
        chk("arst.out_keep", 64'(out_keep), 64'h0_0000_3000);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        chk("arst.occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // iv ic ik ordy fl fk | ev ec ek erdy eocc
        addv(1, 1, pk(32'h3000, 0), 1, 0, 0, 1, 1, pk(32'h3000, 0), 1, 1);
        addv(1, 2, pk(32'h3004, 0), 1, 0, 0, 1, 2, pk(32'h3004, 0), 1, 1);
        addv(1, 3, pk(32'h3008, 0), 1, 0, 0, 1, 3, pk(32'h3008, 0), 1, 1);
        addv(0, 0, pk(32'h3010, 1), 1, 0, 0, 0, 0, pk(32'h3010, 1), 1, 0);
        addv(0, 0, pk(32'h3014, 1), 0, 0, 0, 0, 0, pk(32'h3014, 1), 1, 0);
        addv(1, 7, pk(32'h3020, 0), 0, 0, 0, 1, 7, pk(32'h3020, 0), 1, 1);
        addv(1, 8, pk(32'h3024, 0), 0, 0, 0, 1, 7, pk(32'h3020, 0), 0, 2);
        addv(1, 9, pk(32'h3028, 0), 0, 0, 0, 1, 7, pk(32'h3020, 0), 0, 2);
        addv(1, 9, pk(32'h3028, 0), 1, 0, 0, 1, 8, pk(32'h3024, 0), 1, 1);
        addv(0, 0, pk(32'h3030, 0), 1, 0, 0, 0, 0, pk(32'h3030, 0), 1, 0);
        addv(1, 10, pk(32'h3040, 0), 0, 0, 0, 1, 10, pk(32'h3040, 0), 1, 1);
        addv(1, 11, pk(32'h3044, 0), 0, 0, 0, 1, 10, pk(32'h3040, 0), 0, 2);
        addv(1, 64'h55, pk(32'h3048, 0), 0, 1, 33'h4180, 0, 0, 33'h4180, 1, 0);
        addv(0, 0, pk(32'h3050, 0), 1, 0, 0, 0, 0, pk(32'h3050, 0), 1, 0);
        addv(1, 12, pk(32'h3060, 0), 0, 0, 0, 1, 12, pk(32'h3060, 0), 1, 1);
        addv(1, 13, pk(32'h3064, 0), 1, 1, 33'h4200, 0, 0, 33'h4200, 1, 0);

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vecs[i].iv, vecs[i].ic, vecs[i].ik, vecs[i].ordy, vecs[i].fl, vecs[i].fk);
            model_step();
            @(posedge clk);
            #1;
            chk({t, ".out_valid"}, 64'(out_valid), 64'(vecs[i].ev));
            chk({t, ".out_ctrl"}, out_ctrl, vecs[i].ec);
            chk({t, ".out_keep"}, 64'(out_keep), 64'(vecs[i].ek));
            chk({t, ".in_ready"}, 64'(in_ready), 64'(vecs[i].erdy));
            chk({t, ".occupancy"}, 64'(occupancy), 64'(vecs[i].eocc));
            check_perf(t);
            @(negedge clk);
        end

        for (int i = 0; i < 3000; i++) begin
            logic [CW-1:0] rc;
            logic [KW-1:0] rk;
            logic [KW-1:0] rf;
            rc = {$urandom, $urandom};
            rk = {1'($urandom_range(0, 1)), $urandom};
            rf = {1'($urandom_range(0, 1)), $urandom};
            drive($urandom_range(0, 9) < 7, rc, rk, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0, rf);
            model_step();
            @(posedge clk);
            #1;
            check_model($sformatf("rnd%0d", i));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
